// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants and types for the seven-segment display blocks
package disp_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int DIG_W      = 4;
    localparam int SEG_W      = 7;

    // Segment patterns, bit0 = a ... bit6 = g, active-high
    localparam logic [SEG_W-1:0] SEG_0 = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b1100110;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b1111101;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b1101111;
    localparam logic [SEG_W-1:0] SEG_A = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_B = 7'b1111100;
    localparam logic [SEG_W-1:0] SEG_C = 7'b0111001;
    localparam logic [SEG_W-1:0] SEG_D = 7'b1011110;
    localparam logic [SEG_W-1:0] SEG_E = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_F = 7'b1110001;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg7_dec.sv
// rtl/seg7_dec.sv - combinational hex digit to seven-segment decoder
module seg7_dec
    import disp_pkg::*;
(
    input  logic [DIG_W-1:0] code_i,
    output logic [SEG_W-1:0] seg_o
);

    always_comb begin
        seg_o = SEG_0;
        unique case (code_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
        endcase
    end

endmodule

// File: rtl/led_disp_scan.sv
// rtl/led_disp_scan.sv - six-digit multiplexed display scanner with per-slot blanking
// and a once-per-frame input snapshot.
module led_disp_scan
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_DIGITS*DIG_W-1:0]   i_digits,
    input  logic [NUM_DIGITS-1:0]         i_dp,
    input  logic                          i_blank_lz,
    output logic [SEG_W-1:0]              o_seg,
    output logic                          o_seg_dp,
    output logic [NUM_DIGITS-1:0]         o_seg_enb,
    output logic                          o_frame_tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_V  = CW'(BLANK_CYC);

    logic [CW-1:0]               cnt_q, cnt_d;
    logic [2:0]                  idx_q, idx_d;
    logic [NUM_DIGITS*DIG_W-1:0] digits_q;
    logic [NUM_DIGITS-1:0]       dp_q;
    logic                        lz_q;
    scan_state_e                 state_q;
    logic [SEG_W-1:0]            seg_q;
    logic                        seg_dp_q;
    logic [NUM_DIGITS-1:0]       enb_q;
    logic                        tick_q;

    logic                        cnt_wrap;
    logic                        frame_start;
    logic [DIG_W-1:0]            code_cur;
    logic                        dp_cur;
    logic                        blank_cur;
    logic [NUM_DIGITS-1:0]       hi_zero;
    logic [SEG_W-1:0]            seg_dec;

    always_comb begin
        cnt_wrap    = (cnt_q == CNT_LAST);
        cnt_d       = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d       = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
        end
        frame_start = (cnt_q == '0) && (idx_q == 3'd0);
    end

    // hi_zero[n]: digit n and every digit above it are zero in the snapshot
    always_comb begin
        hi_zero   = '0;
        code_cur  = '0;
        dp_cur    = 1'b0;
        blank_cur = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (i == NUM_DIGITS - 1) begin
                hi_zero[i] = (digits_q[i*DIG_W +: DIG_W] == '0);
            end else begin
                hi_zero[i] = hi_zero[i+1] && (digits_q[i*DIG_W +: DIG_W] == '0);
            end
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == 3'(i)) begin
                code_cur  = digits_q[i*DIG_W +: DIG_W];
                dp_cur    = dp_q[i];
                blank_cur = lz_q && (i != 0) && hi_zero[i];
            end
        end
    end

    seg7_dec u_dec (
        .code_i (code_cur),
        .seg_o  (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            digits_q <= '0;
            dp_q     <= '0;
            lz_q     <= 1'b0;
            state_q  <= ST_BLANK;
            seg_q    <= '0;
            seg_dp_q <= 1'b0;
            enb_q    <= '0;
            tick_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            tick_q <= frame_start;
            if (frame_start) begin
                digits_q <= i_digits;
                dp_q     <= i_dp;
                lz_q     <= i_blank_lz;
            end
            // state_q tracks cnt_q >= BLANK_CYC, so outputs lag the counter by one cycle
            unique case (state_q)
                ST_BLANK: if (cnt_d == BLANK_V) state_q <= ST_DRIVE;
                ST_DRIVE: if (cnt_wrap)         state_q <= ST_BLANK;
            endcase
            if (state_q == ST_DRIVE) begin
                enb_q    <= NUM_DIGITS'(1) << idx_q;
                seg_q    <= blank_cur ? '0 : seg_dec;
                seg_dp_q <= dp_cur;
            end else begin
                enb_q    <= '0;
                seg_q    <= '0;
                seg_dp_q <= 1'b0;
            end
        end
    end

    assign o_seg        = seg_q;
    assign o_seg_dp     = seg_dp_q;
    assign o_seg_enb    = enb_q;
    assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_led_disp_scan.sv
// tb/tb_led_disp_scan.sv - scoreboard bench for led_disp_scan with REFRESH_DIV=8, BLANK_CYC=2
module tb_led_disp_scan;

    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FR = 6 * RD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] digits;
    logic [5:0]  dp;
    logic        lz;
    logic [6:0]  o_seg;
    logic        o_seg_dp;
    logic [5:0]  o_seg_enb;
    logic        o_frame_tick;

    always #5 clk = ~clk;

    led_disp_scan #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_digits     (digits),
        .i_dp         (dp),
        .i_blank_lz   (lz),
        .o_seg        (o_seg),
        .o_seg_dp     (o_seg_dp),
        .o_seg_enb    (o_seg_enb),
        .o_frame_tick (o_frame_tick)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [5:0] enb;
        logic       tick;
    } exp_t;

    logic [6:0] dec_tab [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          e = 0;
    int          smp = 0;
    int          last_tick = -1;
    logic [23:0] m_dig = '0;
    logic [5:0]  m_dp = '0;
    logic        m_lz = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h sample=%0d", tag, obs, expv, smp);
        end
    endtask

    // Expected outputs after edge ed of the frame (edge 0 takes the snapshot)
    function automatic exp_t model(input int ed);
        exp_t       r;
        int         m, c, n;
        logic [3:0] code;
        logic       blank;
        r = '0;
        m = ed % FR;
        c = m % RD;
        n = m / RD;
        r.tick = (m == 0);
        if (c >= BC) begin
            r.enb = 6'b1 << n;
            r.dp  = m_dp[n];
            code  = m_dig[n*4 +: 4];
            blank = m_lz && (n > 0) && ((m_dig >> (n * 4)) == 24'd0);
            r.seg = blank ? 7'd0 : dec_tab[code];
        end
        return r;
    endfunction

    task automatic cycle();
        exp_t x;
        if (rst) begin
            x = '0;
        end else begin
            if (e % FR == 0) begin
                m_dig = digits;
                m_dp  = dp;
                m_lz  = lz;
            end
            x = model(e);
        end
        sb.push_back(x);
        @(posedge clk);
        @(negedge clk);
        smp++;
        x = sb.pop_front();
        check("seg",  32'(o_seg),        32'(x.seg));
        check("dp",   32'(o_seg_dp),     32'(x.dp));
        check("enb",  32'(o_seg_enb),    32'(x.enb));
        check("tick", 32'(o_frame_tick), 32'(x.tick));
        check("onehot", 32'($onehot0(o_seg_enb)), 32'd1);
        if (rst) begin
            e = 0;
            last_tick = -1;
        end else begin
            e++;
            if (o_frame_tick === 1'b1) begin
                if (last_tick >= 0) check("tick_period", 32'(smp - last_tick), 32'(FR));
                last_tick = smp;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        digits = 24'h543210;
        dp     = 6'b000000;
        lz     = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        run(2);
        rst = 1'b0;
        run(FR);

        digits = 24'h000305;
        lz     = 1'b1;
        run(FR);
        digits = 24'h000000;
        run(FR);

        digits = 24'h000305;
        lz     = 1'b0;
        dp     = 6'b000100;
        run(FR);

        // mid-frame input change must wait for the next snapshot
        dp     = 6'b000000;
        digits = 24'h000000;
        rst    = 1'b1;
        cycle();
        rst    = 1'b0;
        run(19);
        digits = 24'h999999;
        run(2 * FR - 19);

        // reset in the middle of a scan
        digits = 24'hFEDCBA;
        dp     = 6'b100001;
        rst    = 1'b1;
        cycle();
        rst    = 1'b0;
        run(29);
        rst    = 1'b1;
        cycle();
        rst    = 1'b0;
        run(60);

        run(3 * FR);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
